// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt aggregator: captures per-pin events into sticky pending/overflow flags,
// presents the lowest-index enabled pending pin and holds it until acked or withdrawn.
module gpio_irq_ctrl #(
   parameter int unsigned N    = 8,
   parameter int unsigned ID_W = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    irq_pin_change,
   input  logic [N-1:0]    irq_int,
   input  logic [N-1:0]    data_in,
   input  logic            global_en,
   input  logic [N-1:0]    irq_enable,
   input  logic [N-1:0]    pend_clr,
   input  logic [N-1:0]    ovf_clr,
   input  logic            irq_ack,
   output logic            irq_valid,
   output logic [ID_W-1:0] irq_id,
   output logic            irq_level,
   output logic [N-1:0]    pending,
   output logic [N-1:0]    overflow
);

   typedef enum logic {StIdle, StActive} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    pending_q, pending_d;
   logic [N-1:0]    overflow_q, overflow_d;
   logic [N-1:0]    level_q, level_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            lvl_q, lvl_d;

   logic [N-1:0]    ev;
   logic [N-1:0]    ack_clr;
   logic [N-1:0]    clr;
   logic [N-1:0]    cand;
   logic [ID_W-1:0] winner;
   logic            cand_any;
   logic            withdraw;

   assign ev   = irq_pin_change | irq_int;
   assign clr  = pend_clr | ack_clr;
   assign cand = pending_q & irq_enable & {N{global_en}};

   // Pending/overflow/level next state; a same-edge event beats any clear.
   always_comb begin
      ack_clr = '0;
      if (state_q == StActive && irq_ack) begin
         ack_clr[id_q] = 1'b1;
      end
      pending_d  = (pending_q & ~clr) | ev;
      overflow_d = (overflow_q & ~ovf_clr) | (ev & pending_q & ~clr);
      level_d    = (level_q & ~ev) | (data_in & ev);
   end

   // Lowest set candidate index wins.
   always_comb begin
      winner   = '0;
      cand_any = |cand;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   // Presentation FSM: latch winner on entry, leave on ack or withdraw.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      lvl_d    = lvl_q;
      // Withdraw only if pend_clr really clears the bit (not overridden by a new event).
      withdraw = !global_en || !irq_enable[id_q] || (pend_clr[id_q] && !ev[id_q]);
      unique case (state_q)
         StIdle: begin
            if (cand_any) begin
               state_d = StActive;
               id_d    = winner;
               lvl_d   = level_d[winner];
            end
         end
         StActive: begin
            if (irq_ack || withdraw) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         pending_q  <= '0;
         overflow_q <= '0;
         level_q    <= '0;
         id_q       <= '0;
         lvl_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         level_q    <= level_d;
         id_q       <= id_d;
         lvl_q      <= lvl_d;
      end
   end

   assign irq_valid = (state_q == StActive);
   assign irq_id    = id_q;
   assign irq_level = lvl_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the aggregator.
module tb_gpio_irq_ctrl;

   localparam int N    = 8;
   localparam int ID_W = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    irq_pin_change = '0, irq_int = '0, data_in = '0;
   logic            global_en = 1'b1;
   logic [N-1:0]    irq_enable = '1, pend_clr = '0, ovf_clr = '0;
   logic            irq_ack = 1'b0;
   logic            irq_valid;
   logic [ID_W-1:0] irq_id;
   logic            irq_level;
   logic [N-1:0]    pending, overflow;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 1'b0;

   // Model state
   bit [N-1:0] m_pend, m_ovf, m_lvl;
   bit         m_pres;
   int         m_id;
   bit         m_plvl;

   gpio_irq_ctrl #(.N(N), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset), .irq_pin_change(irq_pin_change), .irq_int(irq_int),
      .data_in(data_in), .global_en(global_en), .irq_enable(irq_enable),
      .pend_clr(pend_clr), .ovf_clr(ovf_clr), .irq_ack(irq_ack), .irq_valid(irq_valid),
      .irq_id(irq_id), .irq_level(irq_level), .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_ovf = '0; m_lvl = '0; m_pres = 0; m_id = 0; m_plvl = 0;
   endtask

   // One rising edge worth of the rules, applied to the inputs currently driven.
   task automatic model_step();
      bit [N-1:0] old_pend, old_lvl;
      bit         ev, cleared, ack_hit;
      if (!reset) begin
         model_reset();
         return;
      end
      old_pend = m_pend;
      old_lvl  = m_lvl;
      ack_hit  = m_pres && irq_ack;
      if (m_pres) begin
         ev = irq_pin_change[m_id] | irq_int[m_id];
         if (irq_ack || !global_en || !irq_enable[m_id] || (pend_clr[m_id] && !ev))
            m_pres = 0;
      end else if (global_en) begin
         for (int i = 0; i < N; i++) begin
            if (old_pend[i] && irq_enable[i]) begin
               m_pres = 1;
               m_id   = i;
               ev     = irq_pin_change[i] | irq_int[i];
               m_plvl = ev ? data_in[i] : old_lvl[i];
               break;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         ev      = irq_pin_change[i] | irq_int[i];
         cleared = pend_clr[i] || (ack_hit && i == m_id_prev_hack(i));
         if (ev) begin
            m_ovf[i]  = (old_pend[i] && !cleared) ? 1'b1 : (ovf_clr[i] ? 1'b0 : m_ovf[i]);
            m_pend[i] = 1;
            m_lvl[i]  = data_in[i];
         end else begin
            if (ovf_clr[i]) m_ovf[i] = 0;
            if (cleared) m_pend[i] = 0;
         end
      end
   endtask

   // The acked pin is the one that was presented before this edge.
   int ack_pin;
   function automatic int m_id_prev_hack(input int i);
      return ack_pin;
   endfunction

   task automatic drive(input bit [N-1:0] pc, input bit [N-1:0] ii, input bit [N-1:0] din,
                        input bit [N-1:0] pc_clr, input bit [N-1:0] oc, input bit ack);
      irq_pin_change = pc; irq_int = ii; data_in = din;
      pend_clr = pc_clr; ovf_clr = oc; irq_ack = ack;
      ack_pin = m_id;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      drive('0, '0, '0, '0, '0, 1'b0);
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("valid", 32'(irq_valid), 32'(m_pres));
         if (m_pres) begin
            check("id", 32'(irq_id), 32'(m_id));
            check("level", 32'(irq_level), 32'(m_plvl));
         end
         check("pending", 32'(pending), 32'(m_pend));
         check("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   initial begin
      model_reset();
      ack_pin = 0;
      #12;
      check("rst_valid", 32'(irq_valid), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cmp_on = 1'b1;
      idle();
      check("idle_valid", 32'(irq_valid), 32'd0);

      // Single event on pin 5 with level 1
      drive(8'h20, '0, 8'h20, '0, '0, 1'b0);
      check("s_pend", 32'(pending), 32'h20);
      check("s_valid0", 32'(irq_valid), 32'd0);
      idle();
      check("s_valid1", 32'(irq_valid), 32'd1);
      check("s_id", 32'(irq_id), 32'd5);
      check("s_lvl", 32'(irq_level), 32'd1);
      drive('0, '0, '0, '0, '0, 1'b1);
      check("s_ack_valid", 32'(irq_valid), 32'd0);
      check("s_ack_pend", 32'(pending), 32'h0);

      // Priority and hold
      drive(8'h40, 8'h04, '0, '0, '0, 1'b0);
      idle();
      check("p_id2", 32'(irq_id), 32'd2);
      drive(8'h01, '0, '0, '0, '0, 1'b0);
      check("p_hold", 32'(irq_id), 32'd2);
      drive('0, '0, '0, '0, '0, 1'b1);
      check("p_gap", 32'(irq_valid), 32'd0);
      check("p_pend", 32'(pending), 32'h41);
      idle();
      check("p_id0", 32'(irq_id), 32'd0);
      drive('0, '0, '0, '0, '0, 1'b1);
      idle();
      check("p_id6", 32'(irq_id), 32'd6);
      drive('0, '0, '0, '0, '0, 1'b1);
      idle();

      // Overflow and set-wins
      drive(8'h08, '0, '0, '0, '0, 1'b0);
      drive('0, 8'h08, 8'h08, '0, '0, 1'b0);
      check("o_ovf", 32'(overflow), 32'h08);
      check("o_id3", 32'(irq_id), 32'd3);
      drive(8'h08, '0, '0, '0, '0, 1'b1);
      check("o_setwin_pend", 32'(pending), 32'h08);
      check("o_setwin_ovf", 32'(overflow), 32'h08);
      check("o_setwin_valid", 32'(irq_valid), 32'd0);
      idle();
      drive('0, '0, '0, '0, '0, 1'b1);
      drive('0, '0, '0, '0, 8'h08, 1'b0);
      check("o_clr", 32'(overflow), 32'h0);

      // Masking and withdraw
      irq_enable = 8'hEF;
      drive(8'h10, '0, '0, '0, '0, 1'b0);
      idle();
      check("m_pend", 32'(pending), 32'h10);
      check("m_valid", 32'(irq_valid), 32'd0);
      irq_enable = 8'hFF;
      idle();
      check("m_en_valid", 32'(irq_valid), 32'd1);
      check("m_en_id", 32'(irq_id), 32'd4);
      global_en = 1'b0;
      idle();
      check("m_wd_valid", 32'(irq_valid), 32'd0);
      check("m_wd_pend", 32'(pending), 32'h10);
      global_en = 1'b1;
      idle();
      check("m_re_valid", 32'(irq_valid), 32'd1);

      // Asynchronous reset mid-ACTIVE
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("r_valid", 32'(irq_valid), 32'd0);
      check("r_id", 32'(irq_id), 32'd0);
      check("r_lvl", 32'(irq_level), 32'd0);
      check("r_pend", 32'(pending), 32'd0);
      check("r_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      idle();
      idle();
      check("r_after", 32'(irq_valid), 32'd0);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         bit [N-1:0] pc, ii, pcl, oc;
         pc = '0; ii = '0; pcl = '0; oc = '0;
         for (int i = 0; i < N; i++) begin
            pc[i]  = ($urandom_range(0, 9) == 0);
            ii[i]  = ($urandom_range(0, 14) == 0);
            pcl[i] = ($urandom_range(0, 19) == 0);
            oc[i]  = ($urandom_range(0, 9) == 0);
         end
         global_en  = ($urandom_range(0, 9) != 0);
         irq_enable = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         drive(pc, ii, N'($urandom), pcl, oc, $urandom_range(0, 2) == 0);
      end

      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
